// File: rtl/alu_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_pkg
//  Description : Shared ALU control codes, FSM state encoding and op helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_serial_pkg;

    localparam logic [2:0] c_ALU_ADD = 3'h2;
    localparam logic [2:0] c_ALU_SUB = 3'h3;
    localparam logic [2:0] c_ALU_AND = 3'h4;
    localparam logic [2:0] c_ALU_OR  = 3'h5;
    localparam logic [2:0] c_ALU_NOR = 3'h6;
    localparam logic [2:0] c_ALU_XOR = 3'h7;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_RUN  = c_ST_RUN,
        ST_DONE = c_ST_DONE
    } state_t;

    // Arithmetic codes with bit0 set (3'h1, 3'h3) subtract: A + ~B + 1.
    function automatic logic op_inverts_b(input logic [2:0] ctrl);
        return (ctrl[2] == c_ALU_SUB[2]) && (ctrl[0] == c_ALU_SUB[0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_if
//  Description : Operand (valid/ready in) and result (valid/ready out) bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carryout;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, A, B, control, out_ready,
        input  in_ready, out_valid, out, carryout, overflow, zero, negative
    );

    modport slave (
        input  in_valid, A, B, control, out_ready,
        output in_ready, out_valid, out, carryout, overflow, zero, negative
    );
endinterface
`default_nettype wire

// File: rtl/alu_serial_alu1.sv
`default_nettype none
// ============================================================================
//  Module      : alu1
//  Description : 1-bit ALU slice (add/sub with carry, AND/OR/NOR/XOR).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu1
    import alu_serial_pkg::*;
(
    output logic       out,
    output logic       carryout,
    input  wire logic  A,
    input  wire logic  B,
    input  wire logic  carryin,
    input  wire logic [2:0] control
);
    logic w_b;

    assign w_b = B ^ op_inverts_b(control);

    always_comb begin
        out      = 1'b0;
        carryout = 1'b0;
        case (control)
            c_ALU_AND: out = A & B;
            c_ALU_OR:  out = A | B;
            c_ALU_NOR: out = ~(A | B);
            c_ALU_XOR: out = A ^ B;
            default: begin
                out      = A ^ w_b ^ carryin;
                carryout = (A & w_b) | (carryin & (A ^ w_b));
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial
//  Description : Bit-serial WIDTH-bit ALU, one alu1 slice iterated LSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    reset,
    alu_serial_if.slave  bus
);
    localparam int                 c_IDX_W    = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic [WIDTH-1:0]   r_out;
    logic [2:0]         r_ctrl;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic               r_carry;
    logic               r_carryout;
    logic               r_overflow;
    logic               r_in_ready;
    logic               r_out_valid;

    logic               w_slice_out;
    logic               w_slice_cout;
    logic               w_arith;
    logic [WIDTH-1:0]   w_res_next;

    alu1 u_alu1 (
        .out      (w_slice_out),
        .carryout (w_slice_cout),
        .A        (r_a_sh[0]),
        .B        (r_b_sh[0]),
        .carryin  (r_carry),
        .control  (r_ctrl)
    );

    assign w_arith    = ~r_ctrl[2];
    assign w_res_next = {w_slice_out, r_res_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res_sh    <= '0;
            r_out       <= '0;
            r_ctrl      <= c_ALU_ADD;
            r_bit_idx   <= '0;
            r_carry     <= 1'b0;
            r_carryout  <= 1'b0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh     <= bus.A;
                        r_b_sh     <= bus.B;
                        r_ctrl     <= bus.control;
                        r_carry    <= op_inverts_b(bus.control);
                        r_bit_idx  <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_res_sh  <= w_res_next;
                    r_carry   <= w_slice_cout;
                    r_bit_idx <= r_bit_idx + 1'b1;
                    // MSB step: r_carry is still the carry into the MSB here.
                    if (r_bit_idx == c_LAST_IDX) begin
                        r_out       <= w_res_next;
                        r_carryout  <= w_arith & w_slice_cout;
                        r_overflow  <= w_arith & (r_carry ^ w_slice_cout);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.carryout  = r_carryout;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = (r_out == '0);
    assign bus.negative  = r_out[WIDTH-1];
endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_serial
//  Description : Directed self-checking bench for alu_serial (WIDTH = 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    alu_serial_if #(.WIDTH(WIDTH)) bus ();

    alu_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one op, return edges from accept until out_valid (bounded).
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctrl, output int lat);
        bus.A        = a;
        bus.B        = b;
        bus.control  = ctrl;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int  lat;
        logic stable;
        n_pass        = 0;
        n_total       = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.control   = 3'h0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out",       bus.out,       32'h0);
        chk("rst_zero",      bus.zero,      1'b1);
        chk("rst_flags",     {bus.carryout, bus.overflow}, 2'b00);

        issue(32'h7FFF_FFFF, 32'h0000_0001, 3'h2, lat);
        chk("add_latency", lat, 32);
        chk("add_out",     bus.out, 32'h8000_0000);
        chk("add_ov",      bus.overflow, 1'b1);
        chk("add_neg",     bus.negative, 1'b1);
        chk("add_co",      bus.carryout, 1'b0);
        chk("add_zero",    bus.zero, 1'b0);
        chk("done_in_ready", bus.in_ready, 1'b0);
        release_result();
        chk("idle_in_ready", bus.in_ready, 1'b1);
        chk("idle_out_held", bus.out, 32'h8000_0000);

        issue(32'h0000_0005, 32'h0000_0005, 3'h3, lat);
        chk("sub_eq_out",  bus.out, 32'h0);
        chk("sub_eq_zero", bus.zero, 1'b1);
        chk("sub_eq_co",   bus.carryout, 1'b1);
        chk("sub_eq_ov",   bus.overflow, 1'b0);
        release_result();

        issue(32'h8000_0000, 32'h0000_0001, 3'h3, lat);
        chk("sub_ov_out", bus.out, 32'h7FFF_FFFF);
        chk("sub_ov_ov",  bus.overflow, 1'b1);
        chk("sub_ov_co",  bus.carryout, 1'b1);
        chk("sub_ov_neg", bus.negative, 1'b0);
        release_result();

        issue(32'h0000_0000, 32'h0000_0000, 3'h6, lat);
        chk("nor_out",   bus.out, 32'hFFFF_FFFF);
        chk("nor_flags", {bus.carryout, bus.overflow}, 2'b00);
        release_result();

        issue(32'hF0F0_F0F0, 32'hFFFF_0000, 3'h7, lat);
        chk("xor_out", bus.out, 32'h0F0F_F0F0);
        release_result();

        issue(32'hF0F0_F0F0, 32'hFFFF_0000, 3'h4, lat);
        chk("and_out", bus.out, 32'hF0F0_0000);
        release_result();

        issue(32'h1234_0000, 32'h0000_5678, 3'h5, lat);
        chk("or_out", bus.out, 32'h1234_5678);
        release_result();

        // Code 3'h1 aliases SUB: 3 - 5 = -2, borrow so carryout 0.
        issue(32'h0000_0003, 32'h0000_0005, 3'h1, lat);
        chk("sub_alias_out", bus.out, 32'hFFFF_FFFE);
        chk("sub_alias_co",  bus.carryout, 1'b0);
        release_result();

        // Backpressure: 0xFFFFFFFF + 1 = 0, carry out, no overflow.
        issue(32'hFFFF_FFFF, 32'h0000_0001, 3'h2, lat);
        stable = 1'b1;
        bus.A        = 32'h0000_0003;
        bus.B        = 32'h0000_0004;
        bus.control  = 3'h2;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 3) == 1;
            tick();
            if (!bus.out_valid || bus.in_ready || bus.out !== 32'h0 ||
                !bus.carryout || bus.overflow || !bus.zero)
                stable = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("bp_stable",    stable, 1'b1);
        chk("bp_out_valid", bus.out_valid, 1'b1);
        chk("bp_co",        bus.carryout, 1'b1);
        release_result();
        chk("bp_idle_ready", bus.in_ready, 1'b1);
        chk("bp_idle_valid", bus.out_valid, 1'b0);
        tick();
        chk("bp_not_taken", bus.in_ready, 1'b1);

        issue(32'h0000_000A, 32'h0000_0014, 3'h2, lat);
        chk("after_bp_out", bus.out, 32'h0000_001E);
        release_result();

        // Reset while RUN sits at bit_idx 10.
        bus.A        = 32'h1111_1111;
        bus.B        = 32'h2222_2222;
        bus.control  = 3'h2;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_in_ready",  bus.in_ready, 1'b1);
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_out",       bus.out, 32'h0);

        issue(32'h0000_0003, 32'h0000_0004, 3'h2, lat);
        chk("post_rst_latency", lat, 32);
        chk("post_rst_out",     bus.out, 32'h0000_0007);
        release_result();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
